// File: rtl/trace_pkg.sv
// Shared definitions for the trace capture sequencer: default widths,
// capture depth and the sequencer state encoding.
package trace_pkg;

  localparam int TRACE_ADDR_W = 9;
  localparam int TRACE_DATA_W = 8;
  localparam int TRACE_DEPTH  = 1 << TRACE_ADDR_W;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    DELAY,
    CAPTURE,
    DONE
  } state_t;

endpackage

// File: rtl/trace_trig_edge.sv
// Registered rising-edge detector for the encryption-phase trigger.
module trace_trig_edge (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  output logic rise
);

  logic trig_q;

  // NOTE: history resets high so a trigger already asserted at reset release is not an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) trig_q <= 1'b1;
    else     trig_q <= trig;
  end

  assign rise = trig & ~trig_q;

endmodule

// File: rtl/trace_capture_ctrl.sv
// Capture sequencer: arm, wait for trigger edge, delay, then store decimated
// sensor samples into the trace BRAM with an auto-incrementing address.
module trace_capture_ctrl
  import trace_pkg::*;
#(
  parameter int ADDR_W = TRACE_ADDR_W,
  parameter int DATA_W = TRACE_DATA_W,
  parameter int DLY_W  = 8,
  parameter int DEC_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              abort,
  input  logic              trig,
  input  logic [DLY_W-1:0]  cfg_delay,
  input  logic [ADDR_W:0]   cfg_len,
  input  logic [DEC_W-1:0]  cfg_decim,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   n_stored,
  output logic              missed
);

  localparam int              LEN_W = ADDR_W + 1;
  localparam logic [LEN_W-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  state_t            state;
  logic [DLY_W-1:0]  delay_q;
  logic [LEN_W-1:0]  len_q;
  logic [DEC_W-1:0]  decim_q;
  logic [DLY_W-1:0]  dcnt;
  logic [DEC_W-1:0]  dec;
  logic [LEN_W-1:0]  len_eff;
  logic              trig_rise;

  // Zero and oversize lengths both mean a full-depth capture.
  assign len_eff = (cfg_len == '0 || cfg_len > DEPTH) ? DEPTH : cfg_len;

  trace_trig_edge u_trig_edge (
    .clk  (clk),
    .rst  (rst),
    .trig (trig),
    .rise (trig_rise)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      delay_q   <= '0;
      len_q     <= '0;
      decim_q   <= '0;
      dcnt      <= '0;
      dec       <= '0;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      n_stored  <= '0;
      missed    <= 1'b0;
    end else begin
      // NOTE: mem_we defaults low every cycle so each accepted sample gives exactly one pulse.
      mem_we <= 1'b0;
      if (abort) begin
        state <= IDLE;
        done  <= 1'b0;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (arm) begin
              delay_q  <= cfg_delay;
              len_q    <= len_eff;
              decim_q  <= cfg_decim;
              n_stored <= '0;
              missed   <= 1'b0;
              done     <= 1'b0;
              busy     <= 1'b1;
              state    <= ARMED;
            end
          end
          ARMED: begin
            if (trig_rise) begin
              dec <= '0;
              if (delay_q == '0) begin
                state <= CAPTURE;
              end else begin
                dcnt  <= delay_q;
                state <= DELAY;
              end
            end
          end
          DELAY: begin
            if (trig_rise) missed <= 1'b1;
            dcnt <= dcnt - DLY_W'(1);
            if (dcnt == DLY_W'(1)) state <= CAPTURE;
          end
          CAPTURE: begin
            if (trig_rise) missed <= 1'b1;
            if (sample_valid) begin
              if (dec == '0) begin
                dec       <= decim_q;
                mem_we    <= 1'b1;
                mem_waddr <= n_stored[ADDR_W-1:0];
                mem_wdata <= sample_in;
                n_stored  <= n_stored + LEN_W'(1);
                if (n_stored + LEN_W'(1) == len_q) begin
                  state <= DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                end
              end else begin
                dec <= dec - DEC_W'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Self-checking bench for trace_capture_ctrl: directed scenarios plus a
// randomized run, all compared against a behavioural capture model.
module tb_trace_capture_ctrl;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 8;
  localparam int DLY_W  = 8;
  localparam int DEC_W  = 4;
  localparam int LEN_W  = ADDR_W + 1;
  localparam int DEPTH  = 512;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              arm = 1'b0;
  logic              abort = 1'b0;
  logic              trig = 1'b0;
  logic [DLY_W-1:0]  cfg_delay = '0;
  logic [LEN_W-1:0]  cfg_len = '0;
  logic [DEC_W-1:0]  cfg_decim = '0;
  logic [DATA_W-1:0] sample_in = '0;
  logic              sample_valid = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              busy;
  logic              done;
  logic [LEN_W-1:0]  n_stored;
  logic              missed;

  always #5 clk = ~clk;

  trace_capture_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .arm          (arm),
    .abort        (abort),
    .trig         (trig),
    .cfg_delay    (cfg_delay),
    .cfg_len      (cfg_len),
    .cfg_decim    (cfg_decim),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .mem_we       (mem_we),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata),
    .busy         (busy),
    .done         (done),
    .n_stored     (n_stored),
    .missed       (missed)
  );

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              busy;
    logic              done;
    logic [LEN_W-1:0]  n;
    logic              missed;
  } obs_t;

  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  string cur_test = "none";

  // Behavioural model: a capture is "waiting" after arm, then "running" from the
  // trigger edge; samples become eligible at edge index (edge + 1 + delay) and
  // every (decim+1)-th eligible valid sample is stored.
  bit   m_waiting, m_running, m_done, m_missed, m_trig_prev;
  int   m_first, m_vseen, m_count, m_len, m_decim, m_delay;
  obs_t exp_o;

  int wr_count = 0;
  int last_addr = -1;
  int wr_cycles[$];

  task automatic model_reset();
    m_waiting = 0; m_running = 0; m_done = 0; m_missed = 0; m_trig_prev = 1;
    m_first = 0; m_vseen = 0; m_count = 0; m_len = 0; m_decim = 0; m_delay = 0;
    exp_o = '0;
  endtask

  task automatic model_edge(input int c);
    bit rise;
    rise = trig && !m_trig_prev;
    m_trig_prev = trig;
    exp_o.we = 1'b0;
    if (abort) begin
      m_waiting = 0; m_running = 0; m_done = 0;
    end else if (arm && !m_waiting && !m_running) begin
      m_len   = (cfg_len == 0 || int'(cfg_len) > DEPTH) ? DEPTH : int'(cfg_len);
      m_decim = int'(cfg_decim);
      m_delay = int'(cfg_delay);
      m_count = 0; m_missed = 0; m_done = 0; m_waiting = 1;
    end else if (m_waiting) begin
      if (rise) begin
        m_waiting = 0; m_running = 1; m_first = c + 1 + m_delay; m_vseen = 0;
      end
    end else if (m_running) begin
      if (rise) m_missed = 1;
      if (c >= m_first && sample_valid) begin
        if (m_vseen % (m_decim + 1) == 0) begin
          exp_o.we   = 1'b1;
          exp_o.addr = ADDR_W'(m_count);
          exp_o.data = sample_in;
          m_count++;
          if (m_count == m_len) begin
            m_running = 0; m_done = 1;
          end
        end
        m_vseen++;
      end
    end
    exp_o.busy   = m_waiting || m_running;
    exp_o.done   = m_done;
    exp_o.n      = LEN_W'(m_count);
    exp_o.missed = m_missed;
  endtask

  task automatic step();
    obs_t act;
    model_edge(cyc);
    @(posedge clk);
    #1;
    cyc++;
    act = obs_t'({mem_we, mem_waddr, mem_wdata, busy, done, n_stored, missed});
    checks++;
    if (act !== exp_o) begin
      errors++;
      $display("FAIL %s cyc=%0d got we=%b addr=%0d data=%h busy=%b done=%b n=%0d missed=%b expected we=%b addr=%0d data=%h busy=%b done=%b n=%0d missed=%b",
               cur_test, cyc, act.we, act.addr, act.data, act.busy, act.done, act.n, act.missed,
               exp_o.we, exp_o.addr, exp_o.data, exp_o.busy, exp_o.done, exp_o.n, exp_o.missed);
    end
    if (mem_we === 1'b1) begin
      wr_count++;
      last_addr = int'(mem_waddr);
      wr_cycles.push_back(cyc);
    end
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic run_until_done(input int max_cycles);
    int n;
    n = 0;
    while (done !== 1'b1 && n < max_cycles) begin
      sample_in = DATA_W'($urandom);
      step();
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: done=%b after %0d cycles, required 1", cur_test, done, n);
    end
  endtask

  task automatic test_reset();
    cur_test = "reset";
    rst = 1'b1;
    #1;
    checks++;
    if ({mem_we, mem_waddr, mem_wdata, busy, done, n_stored, missed} !== '0) begin
      errors++;
      $display("FAIL reset_async outputs=%h required 0",
               {mem_we, mem_waddr, mem_wdata, busy, done, n_stored, missed});
    end
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    model_reset();
    step();
    step();
  endtask

  task automatic test_basic();
    int wr0;
    cur_test = "basic";
    cfg_delay = '0; cfg_len = LEN_W'(4); cfg_decim = '0; sample_valid = 1'b1;
    trig = 1'b0;
    pulse_arm();
    step();
    wr0 = wr_count;
    trig = 1'b1;
    sample_in = 8'h10;
    step();
    for (int i = 0; i < 4; i++) begin
      sample_in = sample_in + 8'h01;
      step();
    end
    checks++;
    if (done !== 1'b1 || n_stored !== LEN_W'(4) || wr_count - wr0 != 4 || mem_wdata !== 8'h14 || last_addr != 3) begin
      errors++;
      $display("FAIL basic_end done=%b n=%0d writes=%0d data=%h addr=%0d required done=1 n=4 writes=4 data=14 addr=3",
               done, n_stored, wr_count - wr0, mem_wdata, last_addr);
    end
    trig = 1'b0;
    step();
  endtask

  task automatic test_delay_decim();
    int t_obs;
    cur_test = "delay_decim";
    cfg_delay = DLY_W'(5); cfg_len = LEN_W'(2); cfg_decim = DEC_W'(2); sample_valid = 1'b1;
    pulse_arm();
    wr_cycles.delete();
    trig = 1'b1;
    step();
    t_obs = cyc;
    run_until_done(40);
    checks++;
    if (wr_cycles.size() != 2 || wr_cycles[0] - t_obs != 6 || wr_cycles[1] - t_obs != 9) begin
      errors++;
      $display("FAIL delay_decim_timing writes=%0d first=%0d second=%0d required writes=2 first=6 second=9",
               wr_cycles.size(), (wr_cycles.size() > 0) ? wr_cycles[0] - t_obs : -1,
               (wr_cycles.size() > 1) ? wr_cycles[1] - t_obs : -1);
    end
    trig = 1'b0;
    step();
  endtask

  task automatic test_full_depth(input logic [LEN_W-1:0] len);
    int wr0;
    cur_test = (len == '0) ? "full_depth_len0" : "full_depth_clamp";
    cfg_delay = '0; cfg_len = len; cfg_decim = '0; sample_valid = 1'b1;
    pulse_arm();
    wr0 = wr_count;
    trig = 1'b1;
    step();
    run_until_done(DEPTH + 20);
    checks++;
    if (wr_count - wr0 != DEPTH || last_addr != DEPTH - 1 || n_stored !== LEN_W'(DEPTH)) begin
      errors++;
      $display("FAIL %s writes=%0d last_addr=%0d n=%0d required writes=512 last_addr=511 n=512",
               cur_test, wr_count - wr0, last_addr, n_stored);
    end
    trig = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_missed();
    int wr0;
    cur_test = "missed";
    cfg_delay = '0; cfg_len = LEN_W'(8); cfg_decim = DEC_W'(1); sample_valid = 1'b1;
    pulse_arm();
    wr0 = wr_count;
    trig = 1'b1;
    step();
    repeat (3) step();
    trig = 1'b0;
    step();
    trig = 1'b1;
    step();
    run_until_done(40);
    checks++;
    if (missed !== 1'b1 || wr_count - wr0 != 8) begin
      errors++;
      $display("FAIL missed_set missed=%b writes=%0d required missed=1 writes=8", missed, wr_count - wr0);
    end
    trig = 1'b0;
    pulse_arm();
    checks++;
    if (missed !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL missed_clear missed=%b busy=%b done=%b required missed=0 busy=1 done=0", missed, busy, done);
    end
    pulse_abort();
  endtask

  task automatic test_abort();
    int wr0;
    cur_test = "abort";
    cfg_delay = '0; cfg_len = LEN_W'(8); cfg_decim = '0; sample_valid = 1'b1;
    trig = 1'b0;
    pulse_arm();
    wr0 = wr_count;
    trig = 1'b1;
    step();
    repeat (3) step();
    pulse_abort();
    checks++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || n_stored !== LEN_W'(3) || wr_count - wr0 != 3) begin
      errors++;
      $display("FAIL abort_now we=%b busy=%b done=%b n=%0d writes=%0d required we=0 busy=0 done=0 n=3 writes=3",
               mem_we, busy, done, n_stored, wr_count - wr0);
    end
    repeat (5) step();
    checks++;
    if (wr_count - wr0 != 3) begin
      errors++;
      $display("FAIL abort_quiet writes=%0d required 3", wr_count - wr0);
    end
    trig = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    int wr0;
    cur_test = "async_reset";
    cfg_delay = '0; cfg_len = LEN_W'(8); cfg_decim = '0; sample_valid = 1'b1;
    pulse_arm();
    trig = 1'b1;
    step();
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({mem_we, mem_waddr, mem_wdata, busy, done, n_stored, missed} !== '0) begin
      errors++;
      $display("FAIL async_reset_outputs outputs=%h required 0",
               {mem_we, mem_waddr, mem_wdata, busy, done, n_stored, missed});
    end
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    pulse_arm();
    wr0 = wr_count;
    repeat (5) step();
    checks++;
    if (wr_count != wr0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL held_trig writes=%0d busy=%b required writes=0 busy=1", wr_count - wr0, busy);
    end
    trig = 1'b0;
    step();
    trig = 1'b1;
    step();
    run_until_done(20);
    checks++;
    if (wr_count - wr0 != 8) begin
      errors++;
      $display("FAIL retrigger writes=%0d required 8", wr_count - wr0);
    end
    trig = 1'b0;
    step();
  endtask

  task automatic test_random();
    cur_test = "random";
    for (int i = 0; i < 3000; i++) begin
      arm          = ($urandom_range(0, 19) == 0);
      abort        = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 5) == 0) trig = ~trig;
      sample_valid = ($urandom_range(0, 9) < 7);
      sample_in    = DATA_W'($urandom);
      cfg_delay    = DLY_W'($urandom_range(0, 6));
      case ($urandom_range(0, 19))
        0:       cfg_len = '0;
        1:       cfg_len = LEN_W'($urandom_range(513, 1023));
        default: cfg_len = LEN_W'($urandom_range(1, 12));
      endcase
      cfg_decim    = DEC_W'($urandom_range(0, 3));
      step();
    end
    arm = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_delay_decim();
    test_full_depth(LEN_W'(0));
    test_full_depth(LEN_W'(700));
    test_missed();
    test_abort();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
